mem_port_arbiter: RTL and testbench

- Shares one single-ported unified instruction/data memory between the IF stage (fetch) and the MEM stage (LW opcode 4'b1000, SW opcode 4'b1001).
- Drives the external memory request/acknowledge handshake.
- Returns read data to the winning requester.
- Generates the fetch and pipeline stall signals consumed by the pipeline registers.
- Sits between the pipeline and the memory model.

---
 rtl/mem_port_arbiter_pkg.sv | 27 ++
 rtl/mem_arb_timer.sv | 37 +++
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified memory port arbiter: FSM states, grant IDs
// and the load/store opcodes that produce MEM-stage requests.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_BUSY = 2'd1,
      DM_BUSY = 2'd2
   } arb_state_e;

   localparam logic [3:0] OP_LW  = 4'b1000;
   localparam logic [3:0] OP_SW  = 4'b1001;

   localparam logic GNT_IF = 1'b0;
   localparam logic GNT_DM = 1'b1;

   function automatic logic is_mem_op(input logic [3:0] opcode);
      return (opcode == OP_LW) || (opcode == OP_SW);
   endfunction

   // DM wins a tie unless it won the previous grant.
   function automatic logic pick_dm(input logic if_pend, input logic dm_pend,
                                    input logic last_grant);
      return dm_pend & (~if_pend | (last_grant == GNT_IF));
   endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Busy-cycle watchdog for the memory handshake; flags expiry once TIMEOUT
// unacknowledged busy cycles have elapsed since the request was issued.
module mem_arb_timer #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic busy,
   input  logic ack,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT + 2);

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (start) begin
         count_d = '0;
      end else if (busy && !ack && (count_q != CW'(TIMEOUT))) begin
         count_d = count_q + 1'b1;
      end
   end

   assign expired = busy & ~ack & (count_q == CW'(TIMEOUT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported I/D memory between fetch and the MEM stage.
// Define MEM_TIMEOUT_EN to abort unacknowledged requests after TIMEOUT cycles.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   input  logic              dm_read,
   input  logic              dm_write,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_done,
   output logic              stall_if,
   output logic              stall_pipe,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              mem_err
);

   arb_state_e        state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic              if_valid_q, if_valid_d;
   logic              dm_done_q, dm_done_d;
   logic              mem_err_q, mem_err_d;

   logic              if_pend, dm_pend, grant, grant_dm, busy, timeout_hit;
   logic [DATA_W-1:0] ret_data;

   // A requester still holding its request in its own done cycle must not re-win.
   assign if_pend  = if_req & ~if_valid_q;
   assign dm_pend  = (dm_read | dm_write) & ~dm_done_q;
   assign grant    = (state_q == IDLE) & (if_pend | dm_pend);
   assign grant_dm = pick_dm(if_pend, dm_pend, last_grant_q);
   assign busy     = (state_q == IF_BUSY) | (state_q == DM_BUSY);
   assign ret_data = mem_ack ? mem_rdata : '0;

`ifdef MEM_TIMEOUT_EN
   mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (grant),
      .busy    (busy),
      .ack     (mem_ack),
      .expired (timeout_hit)
   );
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
   assign timeout_hit    = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      if_rdata_d   = if_rdata_q;
      dm_rdata_d   = dm_rdata_q;
      if_valid_d   = 1'b0;
      dm_done_d    = 1'b0;
      mem_err_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant) begin
               mem_req_d = 1'b1;
               if (grant_dm) begin
                  last_grant_d = GNT_DM;
                  mem_addr_d   = dm_addr;
                  mem_wdata_d  = dm_wdata;
                  mem_we_d     = dm_write;
                  state_d      = DM_BUSY;
               end else begin
                  last_grant_d = GNT_IF;
                  mem_addr_d   = if_addr;
                  mem_we_d     = 1'b0;
                  state_d      = IF_BUSY;
               end
            end
         end
         IF_BUSY, DM_BUSY: begin
            if (mem_ack || timeout_hit) begin
               mem_req_d = 1'b0;
               mem_err_d = ~mem_ack;
               state_d   = IDLE;
               if (state_q == IF_BUSY) begin
                  if_rdata_d = ret_data;
                  if_valid_d = 1'b1;
               end else begin
                  if (!mem_we_q) begin
                     dm_rdata_d = ret_data;
                  end
                  dm_done_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= GNT_DM;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         if_rdata_q   <= '0;
         dm_rdata_q   <= '0;
         if_valid_q   <= 1'b0;
         dm_done_q    <= 1'b0;
         mem_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         if_rdata_q   <= if_rdata_d;
         dm_rdata_q   <= dm_rdata_d;
         if_valid_q   <= if_valid_d;
         dm_done_q    <= dm_done_d;
         mem_err_q    <= mem_err_d;
      end
   end

   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign if_rdata   = if_rdata_q;
   assign dm_rdata   = dm_rdata_q;
   assign if_valid   = if_valid_q;
   assign dm_done    = dm_done_q;
   assign mem_err    = mem_err_q;
   assign stall_if   = if_req & ~if_valid_q;
   assign stall_pipe = (dm_read | dm_write) & ~dm_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a transaction-level timeline model
// predicts grant order, request windows, done pulses, data and stalls.
module tb_mem_port_arbiter;

   localparam int AW = 8;
   localparam int DW = 16;
   localparam int TO = 15;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic [DW-1:0] if_rdata;
   logic          if_valid;
   logic          dm_read = 1'b0;
   logic          dm_write = 1'b0;
   logic [AW-1:0] dm_addr = '0;
   logic [DW-1:0] dm_wdata = '0;
   logic [DW-1:0] dm_rdata;
   logic          dm_done;
   logic          stall_if, stall_pipe;
   logic          mem_req, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic          mem_ack = 1'b0;
   logic          mem_err;

   int            checks = 0;
   int            errors = 0;
   bit            last_dm = 1'b1;
   logic [DW-1:0] dm_hold = '0;
   bit            spurious = 1'b0;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
      .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_done(dm_done),
      .stall_if(stall_if), .stall_pipe(stall_pipe),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Asserts reset mid-cycle, checks outputs clear without a clock edge, releases away from edges.
   task automatic do_reset();
      #1 rst_n = 1'b0;
      if_req = 1'b0; dm_read = 1'b0; dm_write = 1'b0; mem_ack = 1'b0;
      #1;
      check_val("rst_mem_req", mem_req, 0);
      check_val("rst_mem_we", mem_we, 0);
      check_val("rst_if_valid", if_valid, 0);
      check_val("rst_dm_done", dm_done, 0);
      check_val("rst_mem_err", mem_err, 0);
      check_val("rst_mem_addr", mem_addr, 0);
      check_val("rst_mem_wdata", mem_wdata, 0);
      check_val("rst_if_rdata", if_rdata, 0);
      check_val("rst_dm_rdata", dm_rdata, 0);
      @(posedge clk); @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      last_dm = 1'b1;
      dm_hold = '0;
   endtask

   // One scenario: requests raised together at cycle 0, each held through its done cycle.
   task automatic run_scn(input bit do_if, input bit do_dm, input bit rd, input bit wr,
                          input logic [AW-1:0] ia, input logic [AW-1:0] da,
                          input logic [DW-1:0] wd, input int d_if, input int d_dm,
                          input logic [DW-1:0] data_if, input logic [DW-1:0] data_dm);
      int s[2], a[2], dn[2];
      bit gdm[2];
      int n, if_done, dm_done_c, end_c, win;
      logic [DW-1:0] exp_dm;
      n = 0;
      if (do_if && do_dm) begin
         gdm[0] = !last_dm; gdm[1] = last_dm; n = 2;
      end else if (do_if) begin
         gdm[0] = 1'b0; n = 1;
      end else if (do_dm) begin
         gdm[0] = 1'b1; n = 1;
      end
      if_done = -1; dm_done_c = -1; end_c = 3;
      for (int k = 0; k < n; k++) begin
         s[k]  = (k == 0) ? 1 : dn[k-1] + 1;
         a[k]  = s[k] + (gdm[k] ? d_dm : d_if);
         dn[k] = a[k] + 1;
         if (gdm[k]) dm_done_c = dn[k]; else if_done = dn[k];
         last_dm = gdm[k];
         end_c = dn[k] + 2;
      end
      exp_dm = (do_dm && !wr) ? data_dm : dm_hold;
      if (do_dm) dm_hold = exp_dm;
      if_addr = ia; dm_addr = da; dm_wdata = wd;
      for (int c = 0; c <= end_c; c++) begin
         if_req   = do_if && (c <= if_done);
         dm_read  = do_dm && rd && (c <= dm_done_c);
         dm_write = do_dm && wr && (c <= dm_done_c);
         #1;
         check_val("stall_if", stall_if, if_req && (c != if_done));
         check_val("stall_pipe", stall_pipe, (dm_read || dm_write) && (c != dm_done_c));
         win = -1;
         for (int k = 0; k < n; k++) if (c >= s[k] && c <= a[k]) win = k;
         check_val("mem_req", mem_req, win >= 0);
         if (win >= 0) begin
            check_val("mem_addr", mem_addr, gdm[win] ? da : ia);
            check_val("mem_we", mem_we, gdm[win] && wr);
            if (gdm[win] && wr) check_val("mem_wdata", mem_wdata, wd);
         end
         check_val("if_valid", if_valid, c == if_done);
         check_val("dm_done", dm_done, c == dm_done_c);
         check_val("mem_err", mem_err, 0);
         if (c == if_done) check_val("if_rdata", if_rdata, data_if);
         if (c == dm_done_c) check_val("dm_rdata", dm_rdata, exp_dm);
         mem_rdata = DW'($urandom);
         if (win >= 0 && c == a[win]) begin
            mem_ack   = 1'b1;
            mem_rdata = gdm[win] ? data_dm : data_if;
         end else if (win < 0 && spurious) begin
            mem_ack = ($urandom_range(0, 2) == 0);
         end else begin
            mem_ack = 1'b0;
         end
         @(posedge clk); #1;
      end
      mem_ack = 1'b0;
      $display("scn if=%0b@%0h dm=%0b rd=%0b wr=%0b@%0h d=%0d/%0d if_done=%0d dm_done=%0d",
               do_if, ia, do_dm, rd, wr, da, d_if, d_dm, if_done, dm_done_c);
   endtask

   task automatic reset_mid_access();
      dm_read = 1'b1; dm_addr = 8'h55;
      @(posedge clk); #1;
      check_val("mid_req_up", mem_req, 1);
      @(posedge clk); #1;
      check_val("mid_req_hold", mem_req, 1);
      do_reset();
      for (int c = 0; c < 3; c++) begin
         check_val("mid_no_done", dm_done, 0);
         check_val("mid_req_idle", mem_req, 0);
         @(posedge clk); #1;
      end
      $display("reset mid-access dm read @55");
   endtask

   task automatic timeout_test();
      spurious = 1'b0;
      mem_ack = 1'b0;
      dm_addr = 8'h77;
`ifdef MEM_TIMEOUT_EN
      for (int c = 0; c <= TO + 3; c++) begin
         dm_read = (c <= TO + 2);
         #1;
         check_val("to_mem_req", mem_req, (c >= 1) && (c <= TO + 1));
         check_val("to_dm_done", dm_done, c == TO + 2);
         check_val("to_mem_err", mem_err, c == TO + 2);
         if (c == TO + 2) check_val("to_dm_rdata", dm_rdata, 0);
         @(posedge clk); #1;
      end
      dm_hold = '0;
      last_dm = 1'b1;
      $display("timeout dm read @77 aborted");
`else
      dm_read = 1'b1;
      for (int c = 0; c <= 120; c++) begin
         #1;
         check_val("nto_mem_req", mem_req, c >= 1);
         check_val("nto_dm_done", dm_done, 0);
         check_val("nto_mem_err", mem_err, 0);
         @(posedge clk); #1;
      end
      do_reset();
      $display("no-timeout dm read @77 held 120 cycles");
`endif
   endtask

   initial begin
      do_reset();
      run_scn(1, 1, 1, 0, 8'h20, 8'h44, 16'h0, 1, 2, 16'hBEEF, 16'hCAFE);
      run_scn(1, 0, 0, 0, 8'h10, 8'h00, 16'h0, 1, 0, 16'hA55A, 16'h0);
      run_scn(0, 1, 0, 1, 8'h00, 8'h3C, 16'h1234, 0, 2, 16'h0, 16'h9999);
      run_scn(0, 1, 1, 1, 8'h00, 8'hFF, 16'h5678, 0, 1, 16'h0, 16'h7777);
      run_scn(1, 1, 1, 0, 8'hFF, 8'h00, 16'h0, 0, 0, 16'h1111, 16'h2222);
      spurious = 1'b1;
      for (int i = 0; i < 40; i++) begin
         bit fi, fd, r, w;
         fi = 1'($urandom); fd = 1'($urandom);
         r = 1'($urandom); w = 1'($urandom);
         if (!r && !w) r = 1'b1;
         run_scn(fi, fd, r, w, AW'($urandom), AW'($urandom), DW'($urandom),
                 int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                 DW'($urandom), DW'($urandom));
      end
      spurious = 1'b0;
      reset_mid_access();
      run_scn(1, 1, 1, 0, 8'h01, 8'h02, 16'h0, 2, 0, 16'h0F0F, 16'hF0F0);
      timeout_test();
      run_scn(1, 1, 0, 1, 8'h33, 8'h66, 16'hABCD, 1, 1, 16'h4242, 16'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
